sd_rx_nibble_fifo: RTL and testbench

//   SD-card receive data buffer: packs 4-bit nibbles from the SD DAT[3:0] receive path into
//   32-bit words and queues them in a word FIFO drained by the host/DMA side.

---
 rtl/sd_rx_fifo_pkg.sv | 17 +
 rtl/sd_rx_nibble_packer.sv | 50 +++++
 rtl/sd_rx_nibble_fifo.sv | 72 +++++++
 tb/tb_sd_rx_nibble_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sd_rx_fifo_pkg.sv
// Shared widths, mem_empt bit positions and the optional bus byte-swap helper
// for the SD receive nibble FIFO.
package sd_rx_fifo_pkg;

  localparam int unsigned NIB_W         = 4;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned NIBS_PER_WORD = 8;
  localparam int unsigned IDX_W         = 3;

  localparam int unsigned MEM_EMPT_LE1  = 0;
  localparam int unsigned MEM_EMPT_IDLE = 1;

  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_rx_nibble_packer.sv
// Packs DAT[3:0] nibbles MSB-first into 32-bit words; build option SD_RX_FIFO_BSWAP_EN
// byte-swaps each completed word for a little-endian bus.
module sd_rx_nibble_packer
  import sd_rx_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  d,
  input  logic              wr,
  input  logic              full,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              pending
);

  localparam int unsigned PACK_W = NIB_W * (NIBS_PER_WORD - 1);

  logic [IDX_W-1:0]  idx;
  logic [PACK_W-1:0] pack;
  logic              accept;
  logic              last;
  logic [WORD_W-1:0] raw;

  assign accept = wr & ~full;
  assign last   = (idx == IDX_W'(NIBS_PER_WORD - 1));

  // The first seven nibbles sit in a shift register; the eighth completes the
  // word combinationally so it can be pushed on the same edge it arrives.
  assign raw = {pack, d};

`ifdef SD_RX_FIFO_BSWAP_EN
  assign word = byte_swap(raw);
`else
  assign word = raw;
`endif

  assign word_valid = accept & last;
  assign pending    = (idx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      pack <= '0;
    end else if (accept) begin
      pack <= {pack[PACK_W-NIB_W-1:0], d};
      idx  <= last ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sd_rx_nibble_fifo.sv
// SD receive buffer: nibble packer feeding a 2**ADDR_W x 32 show-ahead word FIFO.
// Optional build macro SD_RX_FIFO_BSWAP_EN selects byte-swapped (little-endian) words.
module sd_rx_nibble_fifo
  import sd_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  d,
  input  logic              wr,
  output logic [WORD_W-1:0] q,
  input  logic              rd,
  output logic              full,
  output logic              empty,
  output logic [1:0]        mem_empt
);

  localparam int unsigned   DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] push_word;
  logic              push;
  logic              pop;
  logic              pending;

  sd_rx_nibble_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .wr         (wr),
    .full       (full),
    .word       (push_word),
    .word_valid (push),
    .pending    (pending)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = rd & ~empty;

  // Gating with empty keeps q at zero after reset without clearing the array.
  assign q = empty ? '0 : mem[rd_ptr];

  assign mem_empt[MEM_EMPT_LE1]  = (count <= (ADDR_W+1)'(1));
  assign mem_empt[MEM_EMPT_IDLE] = empty & ~pending;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_rx_nibble_fifo.sv
// Directed bench for sd_rx_nibble_fifo (default big-endian packing, depth 4).
module tb_sd_rx_nibble_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  d;
  logic        wr;
  logic [31:0] q;
  logic        rd;
  logic        full;
  logic        empty;
  logic [1:0]  mem_empt;

  int checks = 0;
  int errors = 0;

  sd_rx_nibble_fifo #(.ADDR_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .wr       (wr),
    .q        (q),
    .rd       (rd),
    .full     (full),
    .empty    (empty),
    .mem_empt (mem_empt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] nib, input logic w, input logic r);
    d = nib; wr = w; rd = r;
    @(posedge clk); #1;
    d = '0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) cyc(w[31-4*i -: 4], 1'b1, 1'b0);
  endtask

  logic [31:0] hr_words [4];
  logic [31:0] wtmp;
  int          nib_n;
  int          rd_n;
  logic        r_now;

  initial begin
    rst_n = 1'b0; d = '0; wr = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_mem_empt", 32'(mem_empt), 32'h3);
    chk("rst_q", q, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: asynchronous reset with one stored word and a partial word pending
    push_word(32'h1234_5678);
    cyc(4'h9, 1'b1, 1'b0); cyc(4'h9, 1'b1, 1'b0); cyc(4'h9, 1'b1, 1'b0);
    chk("pre_rst_q", q, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_full", 32'(full), 32'd0);
    chk("async_mem_empt", 32'(mem_empt), 32'h3);
    chk("async_q", q, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: one word, first nibble clears mem_empt[1]
    cyc(4'hA, 1'b1, 1'b0);
    chk("nib1_mem_empt", 32'(mem_empt), 32'h1);
    chk("nib1_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 7; i++) begin
      wtmp = 32'hABCD_EFDC;
      cyc(wtmp[27-4*i -: 4], 1'b1, 1'b0);
    end
    chk("w1_empty", 32'(empty), 32'd0);
    chk("w1_q", q, 32'hABCD_EFDC);
    chk("w1_mem_empt", 32'(mem_empt), 32'h1);

    // 3: second word behind the first, then a single read
    push_word(32'hFEDC_BAAB);
    chk("w2_mem_empt", 32'(mem_empt), 32'h0);
    chk("w2_q_head", q, 32'hABCD_EFDC);
    cyc(4'h0, 1'b0, 1'b1);
    chk("rd1_q", q, 32'hFEDC_BAAB);
    chk("rd1_mem_empt", 32'(mem_empt), 32'h1);
    cyc(4'h0, 1'b0, 1'b1);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_mem_empt", 32'(mem_empt), 32'h3);

    // rd while empty must not underflow
    cyc(4'h0, 1'b0, 1'b1);
    chk("rd_empty_ignored", 32'(mem_empt), 32'h3);

    // 4: fill to full, dropped nibbles, push refused under full even with rd
    push_word(32'h0123_4567);
    push_word(32'h89AB_CDEF);
    push_word(32'h1357_9BDF);
    chk("three_full", 32'(full), 32'd0);
    push_word(32'h2468_ACE0);
    chk("four_full", 32'(full), 32'd1);
    chk("four_mem_empt", 32'(mem_empt), 32'h0);
    for (int i = 0; i < 9; i++) cyc(4'hF, 1'b1, 1'b0);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_q", q, 32'h0123_4567);
    cyc(4'h7, 1'b1, 1'b1);
    chk("full_rd_wr_full", 32'(full), 32'd0);
    chk("full_rd_wr_q", q, 32'h89AB_CDEF);
    push_word(32'hDEAD_BEEF);
    chk("refill_full", 32'(full), 32'd1);
    cyc(4'h0, 1'b0, 1'b1);
    chk("pop2_q", q, 32'h1357_9BDF);
    chk("pop2_full", 32'(full), 32'd0);
    cyc(4'h0, 1'b0, 1'b1);
    chk("pop3_q", q, 32'h2468_ACE0);
    cyc(4'h0, 1'b0, 1'b1);
    chk("pop4_q", q, 32'hDEAD_BEEF);
    cyc(4'h0, 1'b0, 1'b1);
    chk("pop_all_empty", 32'(empty), 32'd1);
    chk("pop_all_mem_empt", 32'(mem_empt), 32'h3);

    // 5: pop coinciding with the 8th nibble at count 1
    push_word(32'h55AA_55AA);
    wtmp = 32'hC0FF_EE12;
    for (int i = 0; i < 7; i++) cyc(wtmp[31-4*i -: 4], 1'b1, 1'b0);
    chk("simul_pre_q", q, 32'h55AA_55AA);
    cyc(4'h2, 1'b1, 1'b1);
    chk("simul_q", q, 32'hC0FF_EE12);
    chk("simul_mem_empt", 32'(mem_empt), 32'h1);
    chk("simul_empty", 32'(empty), 32'd0);
    cyc(4'h0, 1'b0, 1'b1);
    chk("simul_drain", 32'(empty), 32'd1);

    // 6: half-rate writes, read whenever a word is available
    hr_words[0] = 32'h3141_5926;
    hr_words[1] = 32'h2718_2818;
    hr_words[2] = 32'hFACE_B00C;
    hr_words[3] = 32'h0BAD_F00D;
    nib_n = 0;
    rd_n  = 0;
    for (int c = 0; c < 80; c++) begin
      r_now = ~empty;
      if (r_now) begin
        if (rd_n < 4) chk($sformatf("hr_q%0d", rd_n), q, hr_words[rd_n]);
        rd_n++;
      end
      if ((c % 2 == 0) && (nib_n < 32)) begin
        wtmp = hr_words[nib_n / 8];
        cyc(wtmp[31-4*(nib_n%8) -: 4], 1'b1, r_now);
        nib_n++;
      end else begin
        cyc(4'h0, 1'b0, r_now);
      end
      if (full) chk("hr_never_full", 32'(full), 32'd0);
    end
    chk("hr_read_count", 32'(rd_n), 32'd4);
    chk("hr_end_mem_empt", 32'(mem_empt), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
